// File: rtl/uart_tx_fpga.sv
// uart_tx_fpga
// Serial UART transmitter feeding the FPGA UART receiver. Bytes arrive over a
// valid/ready handshake. One byte can wait in a single-entry buffer, so
// consecutive frames go out with no idle gap between them.
// Frame on the line: start(0), even parity, d0..d7 (LSB first), stop(1).
// Each bit is held for clksPerBit clock cycles.
//
// Ports:
//   i_clkTx    transmit clock; all logic runs on its rising edge
//   i_rstTx    synchronous, active-high reset
//   i_txValid  a byte is offered on i_txBits
//   i_txBits   byte to transmit
//   o_txReady  buffer can take a byte (combinational, !bufFull)
//   o_txBit    registered serial line, idles high
//   o_txBusy   registered, high while a frame is being shifted out
//   o_txDone   registered one-cycle pulse at the end of each stop bit
module uart_tx_fpga #(
  parameter int clksPerBit = 234
) (
  input  logic       i_clkTx,
  input  logic       i_rstTx,
  input  logic       i_txValid,
  input  logic [7:0] i_txBits,
  output logic       o_txReady,
  output logic       o_txBit,
  output logic       o_txBusy,
  output logic       o_txDone
);

  typedef enum logic [2:0] {
    s_idleTx   = 3'd0,
    s_startTx  = 3'd1,
    s_parityTx = 3'd2,
    s_dataTx   = 3'd3,
    s_stopTx   = 3'd4
  } txState_t;

  localparam logic [7:0] lastCount = 8'(clksPerBit - 1);

  txState_t   state, stateNext;
  logic [7:0] clkCount, clkCountNext;
  logic [3:0] bitIndex, bitIndexNext;
  logic [7:0] shiftData, shiftDataNext;
  logic       parityBit, parityBitNext;
  logic [7:0] bufData, bufDataNext;
  logic       bufFull, bufFullNext;
  logic       lineNext;
  logic       doneNext;
  logic       accept;
  logic       bitEnd;

  assign o_txReady = !bufFull;
  assign accept    = i_txValid && !bufFull;
  assign bitEnd    = (clkCount == lastCount);

  // Next-state logic. The serial line is registered, so its next value is
  // derived from the next state and next shifter contents. That way the line
  // changes in the same cycle as the state does.
  always_comb begin
    stateNext     = state;
    clkCountNext  = clkCount;
    bitIndexNext  = bitIndex;
    shiftDataNext = shiftData;
    parityBitNext = parityBit;
    bufDataNext   = bufData;
    bufFullNext   = bufFull;
    doneNext      = 1'b0;

    // While the shifter is busy, an accepted byte is parked in the buffer.
    // The stop-bit case below may take it straight into the shifter instead.
    if (accept && state != s_idleTx) begin
      bufDataNext = i_txBits;
      bufFullNext = 1'b1;
    end

    case (state)
      s_idleTx: begin
        clkCountNext = 8'd0;
        if (accept) begin
          shiftDataNext = i_txBits;
          parityBitNext = ^i_txBits;
          stateNext     = s_startTx;
        end
      end
      s_startTx: begin
        clkCountNext = bitEnd ? 8'd0 : clkCount + 8'd1;
        if (bitEnd) stateNext = s_parityTx;
      end
      s_parityTx: begin
        clkCountNext = bitEnd ? 8'd0 : clkCount + 8'd1;
        if (bitEnd) begin
          stateNext    = s_dataTx;
          bitIndexNext = 4'd0;
        end
      end
      s_dataTx: begin
        clkCountNext = bitEnd ? 8'd0 : clkCount + 8'd1;
        if (bitEnd) begin
          if (bitIndex == 4'd7) stateNext = s_stopTx;
          else bitIndexNext = bitIndex + 4'd1;
        end
      end
      s_stopTx: begin
        clkCountNext = bitEnd ? 8'd0 : clkCount + 8'd1;
        if (bitEnd) begin
          doneNext = 1'b1;
          if (bufFull) begin
            shiftDataNext = bufData;
            parityBitNext = ^bufData;
            bufFullNext   = 1'b0;
            stateNext     = s_startTx;
          end else if (accept) begin
            // A byte accepted on the very last stop cycle would otherwise sit
            // in the buffer behind an idle shifter. Load it directly instead.
            shiftDataNext = i_txBits;
            parityBitNext = ^i_txBits;
            bufFullNext   = 1'b0;
            stateNext     = s_startTx;
          end else begin
            stateNext = s_idleTx;
          end
        end
      end
      default: begin
        stateNext    = s_idleTx;
        clkCountNext = 8'd0;
      end
    endcase

    case (stateNext)
      s_startTx:  lineNext = 1'b0;
      s_parityTx: lineNext = parityBitNext;
      s_dataTx:   lineNext = shiftDataNext[bitIndexNext[2:0]];
      default:    lineNext = 1'b1;
    endcase
  end

  // State and output registers. Reset abandons any frame in flight and drops
  // the buffered byte.
  always_ff @(posedge i_clkTx) begin
    if (i_rstTx) begin
      state     <= s_idleTx;
      clkCount  <= 8'd0;
      bitIndex  <= 4'd0;
      shiftData <= 8'd0;
      parityBit <= 1'b0;
      bufData   <= 8'd0;
      bufFull   <= 1'b0;
      o_txBit   <= 1'b1;
      o_txBusy  <= 1'b0;
      o_txDone  <= 1'b0;
    end else begin
      state     <= stateNext;
      clkCount  <= clkCountNext;
      bitIndex  <= bitIndexNext;
      shiftData <= shiftDataNext;
      parityBit <= parityBitNext;
      bufData   <= bufDataNext;
      bufFull   <= bufFullNext;
      o_txBit   <= lineNext;
      o_txBusy  <= (stateNext != s_idleTx);
      o_txDone  <= doneNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_fpga.sv
// tb_uart_tx_fpga
// Directed bench for uart_tx_fpga with clksPerBit = 4, so a frame is 44 cycles.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// point, which is well away from the next edge.
module tb_uart_tx_fpga;

  localparam int K = 4;
  localparam int frameLen = 11 * K;

  logic       i_clkTx = 1'b0;
  logic       i_rstTx = 1'b1;
  logic       i_txValid = 1'b0;
  logic [7:0] i_txBits = 8'h00;
  logic       o_txReady;
  logic       o_txBit;
  logic       o_txBusy;
  logic       o_txDone;

  int vectorCount = 0;
  int missCount = 0;

  uart_tx_fpga #(.clksPerBit(K)) dut (
    .i_clkTx   (i_clkTx),
    .i_rstTx   (i_rstTx),
    .i_txValid (i_txValid),
    .i_txBits  (i_txBits),
    .o_txReady (o_txReady),
    .o_txBit   (o_txBit),
    .o_txBusy  (o_txBusy),
    .o_txDone  (o_txDone)
  );

  always #5 i_clkTx = ~i_clkTx;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge i_clkTx);
    #1;
  endtask

  // Offers one byte for a single edge. On return we are in the cycle after
  // the accept edge.
  task automatic applyStimulus(input logic [7:0] data);
    checkOutput("readyBeforeAccept", {31'd0, o_txReady}, 32'd1);
    i_txValid = 1'b1;
    i_txBits  = data;
    nextCycle();
    i_txValid = 1'b0;
    i_txBits  = 8'($urandom);
  endtask

  // Expected line value for cycle c of a frame, with c counted from the
  // first start-bit cycle.
  function automatic logic expectedBit(input logic [7:0] data, input int c);
    int b;
    b = c / K;
    if (b == 0) return 1'b0;
    if (b == 1) return ^data;
    if (b == 10) return 1'b1;
    return data[b - 2];
  endfunction

  // Checks the line and busy from frame cycle 'skip' through the last stop
  // cycle, and leaves us in the cycle right after the stop bit.
  task automatic checkFrame(input logic [7:0] data, input int skip);
    for (int c = skip; c < frameLen; c++) begin
      checkOutput($sformatf("line[%02h]c%0d", data, c), {31'd0, o_txBit},
                  {31'd0, expectedBit(data, c)});
      checkOutput("busyInFrame", {31'd0, o_txBusy}, 32'd1);
      if (c != 0) checkOutput("doneInFrame", {31'd0, o_txDone}, 32'd0);
      nextCycle();
    end
  endtask

  task automatic singleFrame(input logic [7:0] data);
    applyStimulus(data);
    checkFrame(data, 0);
    checkOutput("doneEnd", {31'd0, o_txDone}, 32'd1);
    checkOutput("busyEnd", {31'd0, o_txBusy}, 32'd0);
    checkOutput("lineEnd", {31'd0, o_txBit}, 32'd1);
    nextCycle();
    checkOutput("doneAfter", {31'd0, o_txDone}, 32'd0);
  endtask

  initial begin
    // Reset state
    nextCycle();
    nextCycle();
    i_rstTx = 1'b0;
    checkOutput("rstLine", {31'd0, o_txBit}, 32'd1);
    checkOutput("rstBusy", {31'd0, o_txBusy}, 32'd0);
    checkOutput("rstDone", {31'd0, o_txDone}, 32'd0);
    checkOutput("rstReady", {31'd0, o_txReady}, 32'd1);
    nextCycle();

    // Single frames: parity 0, parity 1, all ones
    singleFrame(8'hA5);
    singleFrame(8'h01);
    singleFrame(8'hFF);

    // Back-to-back 0x00 then 0xFF, with 0x3C refused while the buffer is full
    applyStimulus(8'h00);
    checkOutput("b2bStart", {31'd0, o_txBit}, 32'd0);
    checkOutput("readyFirst", {31'd0, o_txReady}, 32'd1);
    i_txValid = 1'b1;
    i_txBits  = 8'hFF;
    nextCycle();
    checkOutput("readyBuffered", {31'd0, o_txReady}, 32'd0);
    i_txBits = 8'h3C;
    nextCycle();
    checkOutput("readyHeld", {31'd0, o_txReady}, 32'd0);
    nextCycle();
    i_txValid = 1'b0;
    checkFrame(8'h00, 3);
    checkOutput("b2bDone1", {31'd0, o_txDone}, 32'd1);
    checkOutput("readyAfterXfer", {31'd0, o_txReady}, 32'd1);
    checkFrame(8'hFF, 0);
    checkOutput("b2bDone2", {31'd0, o_txDone}, 32'd1);
    checkOutput("b2bBusyEnd", {31'd0, o_txBusy}, 32'd0);
    nextCycle();
    for (int c = 0; c < 2 * K; c++) begin
      checkOutput("refusedIdleLine", {31'd0, o_txBit}, 32'd1);
      checkOutput("refusedIdleBusy", {31'd0, o_txBusy}, 32'd0);
      nextCycle();
    end

    // Reset during the data bits with a byte buffered
    applyStimulus(8'h5A);
    i_txValid = 1'b1;
    i_txBits  = 8'h3C;
    nextCycle();
    i_txValid = 1'b0;
    checkOutput("rstMidBuffered", {31'd0, o_txReady}, 32'd0);
    for (int c = 0; c < 2 * K + 2; c++) nextCycle();
    i_rstTx = 1'b1;
    nextCycle();
    i_rstTx = 1'b0;
    checkOutput("rstMidLine", {31'd0, o_txBit}, 32'd1);
    checkOutput("rstMidBusy", {31'd0, o_txBusy}, 32'd0);
    checkOutput("rstMidReady", {31'd0, o_txReady}, 32'd1);
    for (int c = 0; c < frameLen + K; c++) begin
      nextCycle();
      checkOutput("postRstLine", {31'd0, o_txBit}, 32'd1);
      checkOutput("postRstBusy", {31'd0, o_txBusy}, 32'd0);
      checkOutput("postRstDone", {31'd0, o_txDone}, 32'd0);
    end
    nextCycle();
    singleFrame(8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
